simple_cpu_hs: RTL

Parametrised successor to the team's memory-to-memory SimpleCPU. It runs the same 16-instruction indirect ISA: opcode, immediate bit, and two memory-address fields per word. It adds generic data and address widths, a variable-latency req/ready memory handshake, a per-instruction retire strobe, and halt detection. It sits between a single-port RAM (or the arbiter in front of it) and the testbench or SoC top.

---
 rtl/simple_cpu_pkg.sv | 63 ++++++
 rtl/simple_cpu_alu.sv | 49 ++++
 rtl/simple_cpu_hs.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/simple_cpu_pkg.sv
// Shared definitions for the simple_cpu family: opcode encodings, FSM states,
// instruction-field width and per-opcode access-sequence decode.
package simple_cpu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_LT   = 3'b011;
    localparam logic [2:0] OP_CP   = 3'b100;
    localparam logic [2:0] OP_CPI  = 3'b101;
    localparam logic [2:0] OP_BZJ  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic [2:0] {
        FETCH,
        RD_A,
        RD_B,
        RD_IND,
        WRITE,
        HALT
    } cpuState_t;

    // Which optional steps follow RD_A / RD_B for a given opcode.
    typedef struct packed {
        logic needB;
        logic needInd;
        logic isBranch;
    } opDecode_t;

    // Width of each address field in the instruction word.
    function automatic int unsigned F(input int unsigned dataW);
        return (dataW - 4) / 2;
    endfunction

    function automatic opDecode_t decodeOp(input logic [2:0] op, input logic immBit);
        opDecode_t d;
        d = '0;
        case (op)
            OP_CPI: begin
                d.needB   = 1'b1;
                d.needInd = !immBit;
            end
            OP_BZJ: begin
                d.needB    = !immBit;
                d.isBranch = 1'b1;
            end
            default: d.needB = !immBit;
        endcase
        return d;
    endfunction

    // First state after FETCH; only copies can skip reading *A.
    function automatic cpuState_t firstState(input logic [2:0] op, input logic immBit);
        if (op == OP_CP) begin
            return immBit ? WRITE : RD_B;
        end
        if ((op == OP_CPI) && !immBit) begin
            return RD_B;
        end
        return RD_A;
    endfunction

endpackage

// File: rtl/simple_cpu_alu.sv
// Combinational datapath for simple_cpu: computes the value written by an
// instruction from (op, immediate bit, *A, *B, zero-extended B).
// Ports: op, immBit, a, b, imm in; result_c out.
module simple_cpu_alu
    import simple_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2:0]        op,
    input  logic              immBit,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result_c
);

    localparam logic [DATA_W-1:0] ONE_W = DATA_W'(DATA_W);
    localparam logic [DATA_W-1:0] TWO_W = DATA_W'(2 * DATA_W);

    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] srl;

    // Shift: right below DATA_W, left by the excess up to 2*DATA_W, else zero.
    always_comb begin
        y = immBit ? imm : b;
        if (y < ONE_W) begin
            srl = a >> y;
        end else if (y < TWO_W) begin
            srl = a << (y - ONE_W);
        end else begin
            srl = '0;
        end
    end

    always_comb begin
        result_c = '0;
        case (op)
            OP_ADD:  result_c = a + y;
            OP_NAND: result_c = ~(a & y);
            OP_SRL:  result_c = srl;
            OP_LT:   result_c = DATA_W'(a < y);
            OP_MUL:  result_c = a * y;
            OP_CP:   result_c = y;
            OP_CPI:  result_c = b;
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/simple_cpu_hs.sv
// Memory-to-memory CPU with a req/ready single-port memory interface.
// Each FSM state holds exactly one memory transaction: request is issued the
// cycle after entry and the state advances when mem_req && mem_ready.
// Ports: clk, rst (sync, active-high); mem_req/mem_we/mem_addr/mem_wdata out,
// mem_rdata/mem_ready in; pc, retire (one-cycle pulse), halted (sticky) out.
module simple_cpu_hs
    import simple_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic              halted
);

    localparam int unsigned FW = F(DATA_W);

    cpuState_t         state, stateNxt;
    logic              memReq, memReqNxt;
    logic              memWe, memWeNxt;
    logic [ADDR_W-1:0] memAddr, memAddrNxt;
    logic [DATA_W-1:0] memWdata, memWdataNxt;
    logic [ADDR_W-1:0] pcNxt;
    logic              retireNxt, haltedNxt;
    logic [DATA_W-1:0] iw, iwNxt;
    logic [DATA_W-1:0] valA, valANxt;
    logic [DATA_W-1:0] valB, valBNxt;

    logic [2:0]        op;
    logic              immBit;
    logic [FW-1:0]     fieldA, fieldB;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] writeAddr;
    logic [ADDR_W-1:0] brTarget;
    logic              brTaken;
    logic              resolve;
    logic [DATA_W-1:0] aluResult;
    opDecode_t         dec;

    assign op     = iw[DATA_W-1 -: 3];
    assign immBit = iw[DATA_W-4];
    assign fieldA = iw[2*FW-1 -: FW];
    assign fieldB = iw[FW-1:0];
    assign imm    = DATA_W'(fieldB);
    assign dec    = decodeOp(op, immBit);

    // CPIi writes through the pointer held in *A.
    assign writeAddr = ((op == OP_CPI) && immBit) ? valA[ADDR_W-1:0] : fieldA[ADDR_W-1:0];

    simple_cpu_alu #(.DATA_W(DATA_W)) alu (
        .op       (op),
        .immBit   (immBit),
        .a        (valA),
        .b        (valB),
        .imm      (imm),
        .result_c (aluResult)
    );

    // Reset forces the memory interface quiet within the reset cycle itself.
    assign mem_req   = memReq & ~rst;
    assign mem_we    = memWe & ~rst;
    assign mem_addr  = rst ? '0 : memAddr;
    assign mem_wdata = rst ? '0 : memWdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            pc       <= '0;
            retire   <= 1'b0;
            halted   <= 1'b0;
            iw       <= '0;
            valA     <= '0;
            valB     <= '0;
        end else begin
            state    <= stateNxt;
            memReq   <= memReqNxt;
            memWe    <= memWeNxt;
            memAddr  <= memAddrNxt;
            memWdata <= memWdataNxt;
            pc       <= pcNxt;
            retire   <= retireNxt;
            halted   <= haltedNxt;
            iw       <= iwNxt;
            valA     <= valANxt;
            valB     <= valBNxt;
        end
    end

    always_comb begin
        stateNxt    = state;
        memReqNxt   = memReq;
        memWeNxt    = memWe;
        memAddrNxt  = memAddr;
        memWdataNxt = memWdata;
        pcNxt       = pc;
        retireNxt   = 1'b0;
        haltedNxt   = halted;
        iwNxt       = iw;
        valANxt     = valA;
        valBNxt     = valB;
        resolve     = 1'b0;

        // BZJi resolves at RD_A (*A + B, always taken); BZJ at RD_B (*B == 0).
        brTarget = (state == RD_A) ? ADDR_W'(mem_rdata[ADDR_W-1:0] + fieldB[ADDR_W-1:0])
                                   : valA[ADDR_W-1:0];
        brTaken  = (state == RD_A) || (mem_rdata == '0);

        if (state != HALT) begin
            if (!memReq) begin
                memReqNxt = 1'b1;
                memWeNxt  = 1'b0;
                case (state)
                    FETCH:  memAddrNxt = pc;
                    RD_A:   memAddrNxt = fieldA[ADDR_W-1:0];
                    RD_B:   memAddrNxt = fieldB[ADDR_W-1:0];
                    RD_IND: memAddrNxt = valB[ADDR_W-1:0];
                    WRITE: begin
                        memAddrNxt  = writeAddr;
                        memWeNxt    = 1'b1;
                        memWdataNxt = aluResult;
                    end
                    default: ;
                endcase
            end else if (mem_ready) begin
                memReqNxt = 1'b0;
                memWeNxt  = 1'b0;
                case (state)
                    FETCH: begin
                        iwNxt    = mem_rdata;
                        stateNxt = firstState(mem_rdata[DATA_W-1 -: 3], mem_rdata[DATA_W-4]);
                    end
                    RD_A: begin
                        valANxt = mem_rdata;
                        if (dec.needB) begin
                            stateNxt = RD_B;
                        end else if (dec.isBranch) begin
                            resolve = 1'b1;
                        end else begin
                            stateNxt = WRITE;
                        end
                    end
                    RD_B: begin
                        valBNxt = mem_rdata;
                        if (dec.needInd) begin
                            stateNxt = RD_IND;
                        end else if (dec.isBranch) begin
                            resolve = 1'b1;
                        end else begin
                            stateNxt = WRITE;
                        end
                    end
                    RD_IND: begin
                        valBNxt  = mem_rdata;
                        stateNxt = WRITE;
                    end
                    WRITE: begin
                        pcNxt     = pc + ADDR_W'(1);
                        retireNxt = 1'b1;
                        stateNxt  = FETCH;
                    end
                    default: ;
                endcase

                // A taken branch onto itself is the halt idiom.
                if (resolve) begin
                    retireNxt = 1'b1;
                    stateNxt  = FETCH;
                    if (brTaken) begin
                        pcNxt = brTarget;
                        if (brTarget == pc) begin
                            stateNxt  = HALT;
                            haltedNxt = 1'b1;
                        end
                    end else begin
                        pcNxt = pc + ADDR_W'(1);
                    end
                end
            end
        end
    end

endmodule
